// File: rtl/seg_pkg.sv
// seg_pkg: shared state encoding and widths for the seven-segment scan path.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package seg_pkg;

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] SHOW = 2'd1;
  localparam logic [1:0] GAP  = 2'd2;

  typedef enum logic [1:0] {
    ST_IDLE = IDLE,
    ST_SHOW = SHOW,
    ST_GAP  = GAP
  } state_t;

  // Number of multiplexed digits driven by the scan index.
  localparam int SEG_DIGITS = 4;

  // Width of the blanking-gap counter (gap length 0..15).
  localparam int GAP_W = 4;

endpackage

// File: rtl/seg_prescaler.sv
// seg_prescaler: loadable down-counter with reload register, zero clamp on load, zero flag, restart.
// Latency: load lands in the reload register on the next edge; restart copies the pre-load value.
// Backpressure: none; dec is ignored once the count reaches zero (never wraps).
module seg_prescaler #(
  parameter int               DIV_W      = 20,
  parameter logic [DIV_W-1:0] RELOAD_RST = DIV_W'(49999)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             load,
  input  logic [DIV_W-1:0] load_value,
  input  logic             restart,
  input  logic             dec,
  output logic             zero
);

  logic [DIV_W-1:0] reload_q;
  logic [DIV_W-1:0] cnt_q;

  // Reload register; a zero request is stored as 1 so a phase can never vanish.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      reload_q <= RELOAD_RST;
    end else if (load) begin
      reload_q <= (load_value == '0) ? DIV_W'(1) : load_value;
    end
  end

  // Counter: restart takes the current (old) reload value, otherwise count down and hold at zero.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (restart) begin
      cnt_q <= reload_q;
    end else if (dec && (cnt_q != '0)) begin
      cnt_q <= cnt_q - DIV_W'(1);
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/seg_scan_ctrl.sv
// seg_scan_ctrl: digit-scan timing for the 4-digit display (index, blanking gap, digit/frame strobes).
// Latency: all outputs registered; digit period = reload+1+GAP_CYC cycles, index advances on GAP entry.
// Backpressure: none; scan_en low freezes the index and blanks. Optional blink: SEG_SCAN_BLINK_EN.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int               DIV_W        = 20,
  parameter logic [DIV_W-1:0] DIV_DEFAULT  = DIV_W'(49999),
  parameter int               GAP_CYC      = 4,
  parameter int               BLINK_FRAMES = 64
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             scan_en,
  input  logic             div_load,
  input  logic [DIV_W-1:0] div_value,
  input  logic             blink_en,
  output logic [1:0]       Scanning,
  output logic             blank,
  output logic             digit_tick,
  output logic             frame_tick
);

  // Value loaded into the gap counter on GAP entry; GAP then lasts GAP_CYC cycles.
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_CYC > 0) ? GAP_CYC - 1 : 0);
  localparam logic [1:0]       LAST_IDX = 2'(SEG_DIGITS - 1);

  state_t           state_q;
  state_t           state_d;
  logic [GAP_W-1:0] gap_q;
  logic [GAP_W-1:0] gap_d;
  logic             restart;
  logic             advance;
  logic             dec;
  logic             cnt_zero;
  logic             force_blank;

  assign dec = (state_q == ST_SHOW);

  seg_prescaler #(
    .DIV_W      (DIV_W),
    .RELOAD_RST (DIV_DEFAULT)
  ) u_prescaler (
    .clk        (clk),
    .rst        (rst),
    .load       (div_load),
    .load_value (div_value),
    .restart    (restart),
    .dec        (dec),
    .zero       (cnt_zero)
  );

  // Next-state logic: scan_en low wins from any state and never produces an advance.
  always_comb begin
    state_d = state_q;
    gap_d   = gap_q;
    restart = 1'b0;
    advance = 1'b0;
    if (!scan_en) begin
      state_d = ST_IDLE;
      gap_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_SHOW;
          restart = 1'b1;
        end
        ST_SHOW: begin
          if (cnt_zero) begin
            advance = 1'b1;
            if (GAP_CYC > 0) begin
              state_d = ST_GAP;
              gap_d   = GAP_LAST;
            end else begin
              restart = 1'b1;
            end
          end
        end
        ST_GAP: begin
          if (gap_q == '0) begin
            state_d = ST_SHOW;
            restart = 1'b1;
          end else begin
            gap_d = gap_q - GAP_W'(1);
          end
        end
        default: begin
          state_d = ST_IDLE;
          gap_d   = '0;
        end
      endcase
    end
  end

  // State and registered outputs; blank is derived from the next state so it lines up with the phase.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      gap_q      <= '0;
      Scanning   <= 2'd0;
      blank      <= 1'b1;
      digit_tick <= 1'b0;
      frame_tick <= 1'b0;
    end else begin
      state_q    <= state_d;
      gap_q      <= gap_d;
      if (advance) begin
        Scanning <= Scanning + 2'd1;
      end
      digit_tick <= advance;
      frame_tick <= advance && (Scanning == LAST_IDX);
      blank      <= (state_d != ST_SHOW) || force_blank;
    end
  end

`ifdef SEG_SCAN_BLINK_EN
  localparam int FRAME_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;
  localparam logic [FRAME_W-1:0] FRAME_LAST = FRAME_W'(BLINK_FRAMES - 1);

  logic [FRAME_W-1:0] frame_cnt_q;
  logic               phase_q;
  logic               phase_d;
  logic               frame_evt;

  assign frame_evt = advance && (Scanning == LAST_IDX);

  // Blink phase flips once every BLINK_FRAMES wraps; dropping blink_en resets it.
  always_comb begin
    phase_d = phase_q;
    if (!blink_en) begin
      phase_d = 1'b0;
    end else if (frame_evt && (frame_cnt_q == FRAME_LAST)) begin
      phase_d = ~phase_q;
    end
  end

  // Frame counter and phase register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      frame_cnt_q <= '0;
      phase_q     <= 1'b0;
    end else begin
      phase_q <= phase_d;
      if (!blink_en) begin
        frame_cnt_q <= '0;
      end else if (frame_evt) begin
        frame_cnt_q <= (frame_cnt_q == FRAME_LAST) ? '0 : frame_cnt_q + FRAME_W'(1);
      end
    end
  end

  assign force_blank = blink_en && phase_d;
`else
  localparam int unused_blink_frames = BLINK_FRAMES;
  logic unused_blink_en;
  assign unused_blink_en = blink_en;
  assign force_blank     = 1'b0;
`endif

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// tb_seg_scan_ctrl: directed checks of scan timing, reload handling, enable drop and async reset.
// Main DUT: reload 3, gap 4 (8-cycle digit); second DUT: reload 1, gap 0 (2-cycle digit).
// Observed vector per cycle is {Scanning, blank, digit_tick, frame_tick}.
module tb_seg_scan_ctrl;

  localparam int DIV_W = 20;

  logic             clk = 1'b0;
  logic             rst;
  logic             scan_en;
  logic             div_load;
  logic [DIV_W-1:0] div_value;
  logic             blink_en;
  logic [1:0]       scanning;
  logic             blank;
  logic             digit_tick;
  logic             frame_tick;

  logic             scan_en0;
  logic [1:0]       scanning0;
  logic             blank0;
  logic             digit_tick0;
  logic             frame_tick0;

  logic [4:0]       obs;
  logic [4:0]       obs0;

  int vectors     = 0;
  int miscompares = 0;

  assign obs  = {scanning, blank, digit_tick, frame_tick};
  assign obs0 = {scanning0, blank0, digit_tick0, frame_tick0};

  always #5 clk = ~clk;

  seg_scan_ctrl #(
    .DIV_W        (DIV_W),
    .DIV_DEFAULT  (20'd3),
    .GAP_CYC      (4),
    .BLINK_FRAMES (2)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en),
    .div_load   (div_load),
    .div_value  (div_value),
    .blink_en   (blink_en),
    .Scanning   (scanning),
    .blank      (blank),
    .digit_tick (digit_tick),
    .frame_tick (frame_tick)
  );

  seg_scan_ctrl #(
    .DIV_W        (DIV_W),
    .DIV_DEFAULT  (20'd1),
    .GAP_CYC      (0),
    .BLINK_FRAMES (2)
  ) dut0 (
    .clk        (clk),
    .rst        (rst),
    .scan_en    (scan_en0),
    .div_load   (1'b0),
    .div_value  ({DIV_W{1'b0}}),
    .blink_en   (1'b0),
    .Scanning   (scanning0),
    .blank      (blank0),
    .digit_tick (digit_tick0),
    .frame_tick (frame_tick0)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Hold reset for two edges, release it away from the edge with everything idle.
  task automatic do_reset();
    rst       = 1'b1;
    scan_en   = 1'b0;
    scan_en0  = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    blink_en  = 1'b0;
    step();
    step();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst       = 1'b1;
    scan_en   = 1'b0;
    scan_en0  = 1'b0;
    div_load  = 1'b0;
    div_value = '0;
    blink_en  = 1'b0;
    #2;
    vectors++;
    if (scanning !== 2'd0) begin
      miscompares++;
      $display("FAIL reset_scanning got %0d want 0", scanning);
    end
    vectors++;
    if (blank !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_blank got %b want 1", blank);
    end
    vectors++;
    if (digit_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_digit_tick got %b want 0", digit_tick);
    end
    vectors++;
    if (frame_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL reset_frame_tick got %b want 0", frame_tick);
    end
    vectors++;
    if (obs0 !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_dut0 got %b want 00100", obs0);
    end
    step();
    step();
    rst = 1'b0;
    // Stays idle and blanked with scan_en low.
    step();
    vectors++;
    if (obs !== 5'b00100) begin
      miscompares++;
      $display("FAIL reset_idle got %b want 00100", obs);
    end
  endtask

  // Digit every 8 cycles: 4 SHOW (blank 0) then 4 GAP (blank 1), tick on first GAP cycle.
  task automatic test_scan();
    logic [4:0] exp_v;
    int p;
    int nframe = 0;
    int ndigit = 0;
    do_reset();
    scan_en = 1'b1;
    for (int c = 1; c <= 40; c++) begin
      step();
      p = (c - 1) % 8;
      exp_v[4:3] = 2'((c + 3) / 8);
      exp_v[2]   = (p >= 4);
      exp_v[1]   = (p == 4);
      exp_v[0]   = (p == 4) && (exp_v[4:3] == 2'd0);
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL scan c=%0d got %b want %b", c, obs, exp_v);
      end
      if (c <= 32 && frame_tick === 1'b1) nframe++;
      if (digit_tick === 1'b1) ndigit++;
    end
    vectors++;
    if (nframe != 1) begin
      miscompares++;
      $display("FAIL scan_frames_per_32 got %0d want 1", nframe);
    end
    vectors++;
    if (ndigit != 5) begin
      miscompares++;
      $display("FAIL scan_digits_per_40 got %0d want 5", ndigit);
    end
  endtask

  // Reload of 0 (stored as 1) lands mid-SHOW: first digit keeps old rate, then 2-cycle SHOW.
  task automatic test_div_load();
    logic [4:0] exp_v;
    int d;
    do_reset();
    scan_en = 1'b1;
    for (int c = 1; c <= 18; c++) begin
      step();
      if (c < 5) begin
        exp_v = 5'b00000;
      end else begin
        d = (c - 5) % 6;
        exp_v[4:3] = 2'(1 + (c - 5) / 6);
        exp_v[2]   = (d < 4);
        exp_v[1]   = (d == 0);
        exp_v[0]   = 1'b0;
      end
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL div_load c=%0d got %b want %b", c, obs, exp_v);
      end
      if (c == 2) begin
        div_load  = 1'b1;
        div_value = '0;
      end
      if (c == 3) div_load = 1'b0;
    end
  endtask

  // Load coincident with the GAP->SHOW reload: that SHOW still uses 3, the next uses 1.
  task automatic test_load_coincident();
    logic [4:0] exp_v;
    int p;
    int d;
    do_reset();
    scan_en = 1'b1;
    for (int c = 1; c <= 20; c++) begin
      step();
      if (c <= 12) begin
        p = (c - 1) % 8;
        exp_v[4:3] = 2'((c + 3) / 8);
        exp_v[2]   = (p >= 4);
        exp_v[1]   = (p == 4);
        exp_v[0]   = 1'b0;
      end else begin
        d = (c - 13) % 6;
        exp_v[4:3] = 2'(2 + (c - 13) / 6);
        exp_v[2]   = (d < 4);
        exp_v[1]   = (d == 0);
        exp_v[0]   = 1'b0;
      end
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL load_coincident c=%0d got %b want %b", c, obs, exp_v);
      end
      if (c == 8) begin
        div_load  = 1'b1;
        div_value = 20'd1;
      end
      if (c == 9) div_load = 1'b0;
    end
  endtask

  // Drop scan_en in the GAP after index 2, then resume: full SHOW at 2 before the next tick.
  task automatic test_scan_en_drop();
    logic [4:0] exp_v;
    int p;
    int d;
    do_reset();
    scan_en = 1'b1;
    for (int c = 1; c <= 26; c++) begin
      step();
      if (c <= 14) begin
        p = (c - 1) % 8;
        exp_v[4:3] = 2'((c + 3) / 8);
        exp_v[2]   = (p >= 4);
        exp_v[1]   = (p == 4);
        exp_v[0]   = 1'b0;
      end else if (c <= 17) begin
        exp_v = 5'b10100;
      end else begin
        d = (c - 18) % 8;
        exp_v[4:3] = 2'(2 + (c - 18 + 4) / 8);
        exp_v[2]   = (d >= 4);
        exp_v[1]   = (d == 4);
        exp_v[0]   = 1'b0;
      end
      vectors++;
      if (obs !== exp_v) begin
        miscompares++;
        $display("FAIL scan_en_drop c=%0d got %b want %b", c, obs, exp_v);
      end
      if (c == 14) scan_en = 1'b0;
      if (c == 17) scan_en = 1'b1;
    end
  endtask

  // Async reset between edges while showing index 3.
  task automatic test_async_reset();
    do_reset();
    scan_en = 1'b1;
    repeat (26) step();
    vectors++;
    if (obs !== 5'b11000) begin
      miscompares++;
      $display("FAIL async_pre got %b want 11000", obs);
    end
    #3;
    rst = 1'b1;
    #2;
    vectors++;
    if (obs !== 5'b00100) begin
      miscompares++;
      $display("FAIL async_between_edges got %b want 00100", obs);
    end
    step();
    vectors++;
    if (obs !== 5'b00100) begin
      miscompares++;
      $display("FAIL async_held got %b want 00100", obs);
    end
    rst = 1'b0;
    step();
    vectors++;
    if (obs !== 5'b00000) begin
      miscompares++;
      $display("FAIL async_restart got %b want 00000", obs);
    end
  endtask

  // Zero-gap build, reload 1: index advances every 2 cycles, never blanks.
  task automatic test_gap0();
    logic [4:0] exp_v;
    do_reset();
    scan_en0 = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      step();
      exp_v[4:3] = 2'((c - 1) / 2);
      exp_v[2]   = 1'b0;
      exp_v[1]   = (c >= 3) && (c % 2 == 1);
      exp_v[0]   = (c >= 3) && (c % 2 == 1) && (exp_v[4:3] == 2'd0);
      vectors++;
      if (obs0 !== exp_v) begin
        miscompares++;
        $display("FAIL gap0 c=%0d got %b want %b", c, obs0, exp_v);
      end
    end
  endtask

  // Default build: blink_en has no effect on blank across several frames.
  task automatic test_blink_ignored();
    int p;
    logic exp_b;
    do_reset();
    blink_en = 1'b1;
    scan_en  = 1'b1;
    for (int c = 1; c <= 140; c++) begin
      step();
      p = (c - 1) % 8;
      exp_b = (p >= 4);
      if (c % 4 == 2) begin
        vectors++;
        if (blank !== exp_b) begin
          miscompares++;
          $display("FAIL blink_ignored c=%0d got %b want %b", c, blank, exp_b);
        end
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog timeout vectors=%0d", vectors);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_scan();
    test_div_load();
    test_load_coincident();
    test_scan_en_drop();
    test_async_reset();
    test_gap0();
    test_blink_ignored();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
